// File: rtl/frequency_analyzer_pkg.sv
// ---------------------------------------------------------------------------
// frequency_analyzer_pkg
//
// Purpose:
//   Definitions shared by the frequency analyzer manager and the result
//   reader that sit on the same register bank: register-access op codes,
//   the default result-register count, the reader FSM state encoding and a
//   helper that maps a result-register index onto its pixel.
//
// Contents:
//   REG_OP_NOP / REG_OP_READ / REG_OP_WRITE  register_operation codes
//   DEFAULT_NUM_REGISTERS                    result registers per burst (7)
//   PIXEL_COUNT                              pixels covered by registers 1..6
//   reader_state_e                           result reader FSM states
//   pixel_mask()                             one-hot pixel select for an index
// ---------------------------------------------------------------------------
package frequency_analyzer_pkg;

  localparam logic [1:0] REG_OP_NOP   = 2'd0;
  localparam logic [1:0] REG_OP_READ  = 2'd1;
  localparam logic [1:0] REG_OP_WRITE = 2'd2;

  // f0/f1 for three pixels plus one trailing "unknown" register.
  localparam int DEFAULT_NUM_REGISTERS = 7;
  localparam int PIXEL_COUNT           = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } reader_state_e;

  // Registers 1/2 belong to pixel 0, 3/4 to pixel 1, 5/6 to pixel 2.
  // Anything else (including the trailing register 7) selects no pixel.
  function automatic logic [PIXEL_COUNT-1:0] pixel_mask(input logic [3:0] index);
    logic [PIXEL_COUNT-1:0] mask;
    mask = '0;
    case (index)
      4'd1, 4'd2: mask = 3'b001;
      4'd3, 4'd4: mask = 3'b010;
      4'd5, 4'd6: mask = 3'b100;
      default:    mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/frequency_result_reader_irq_edge_detector.sv
// ---------------------------------------------------------------------------
// irq_edge_detector
//
// Purpose:
//   Registers a level input once per clock and reports a rising edge as
//   level_i & ~level_q. The pulse is high for exactly the cycle in which the
//   level is first seen high, so a level held high afterwards produces no
//   further pulses. Usable by both the manager and the result reader.
//
// Ports:
//   clk_i    in   1  clock
//   reset_i  in   1  synchronous active-high reset (clears the history)
//   level_i  in   1  level to watch
//   rise_o   out  1  one-cycle rising-edge pulse
// ---------------------------------------------------------------------------
module irq_edge_detector (
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  // History is cleared in reset, so a level already high when reset is
  // released counts as a fresh edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/frequency_result_reader.sv
// ---------------------------------------------------------------------------
// frequency_result_reader
//
// Purpose:
//   Reader-side partner of the frequency analyzer manager. A rising edge on
//   the manager's completion level starts a burst that reads result
//   registers 1..NUM_REGISTERS through the register-access port, one at a
//   time, and presents each value on a valid/ready stream. Each beat takes
//   ISSUE (1) + WAIT (READ_LATENCY-1) + CAPTURE (1) + PRESENT (>=1) cycles.
//
// Parameters:
//   NUM_REGISTERS     result registers read per burst (default 7)
//   READ_LATENCY      cycles from the issue cycle to valid read data (1..3)
//   DETECT_THRESHOLD  minimum count flagging a detection (detect build only)
//
// Ports:
//   s00_axi_aclk        in   1   clock
//   s00_axi_areset      in   1   synchronous active-high reset
//   irq                 in   1   manager completion level
//   register_operation  out  2   REG_OP_NOP or REG_OP_READ
//   register_number     out  8   register index being read (1-based)
//   register_read       in   32  read data, READ_LATENCY cycles after issue
//   result_data         out  32  captured register value
//   result_index        out  4   register number of result_data
//   result_last         out  1   high on the final beat of a burst
//   result_valid        out  1   stream valid
//   result_ready        in   1   stream ready
//   busy                out  1   burst in progress
//   done                out  1   one-cycle pulse after the final handshake
//   overrun             out  1   sticky: irq edge seen while a burst ran
//   detect              out  3   per-pixel detection flags
//
// Configuration:
//   FREQ_READER_DETECT_EN  when defined, captured values of registers 1..6
//                          are compared against DETECT_THRESHOLD and the
//                          per-pixel hits accumulate in detect. When not
//                          defined, detect is tied to zero.
// ---------------------------------------------------------------------------
module frequency_result_reader
  import frequency_analyzer_pkg::*;
#(
  parameter int NUM_REGISTERS    = DEFAULT_NUM_REGISTERS,
  parameter int READ_LATENCY     = 1,
  parameter int DETECT_THRESHOLD = 100
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_areset,
  input  logic        irq,
  output logic [1:0]  register_operation,
  output logic [7:0]  register_number,
  input  logic [31:0] register_read,
  output logic [31:0] result_data,
  output logic [3:0]  result_index,
  output logic        result_last,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [2:0]  detect
);

  localparam logic [3:0] LAST_INDEX = 4'(NUM_REGISTERS);
  localparam bit         HAS_WAIT   = (READ_LATENCY > 1);
  // WAIT runs until the counter reaches zero, so it is loaded with the
  // number of extra wait cycles minus one.
  localparam logic [1:0] WAIT_LOAD  = HAS_WAIT ? 2'(READ_LATENCY - 2) : 2'd0;

  logic          start;
  reader_state_e state_q;
  logic [3:0]    index_q;
  logic [3:0]    next_index;
  logic [1:0]    wait_cnt_q;
  logic [1:0]    op_q;
  logic [7:0]    number_q;
  logic [31:0]   data_q;
  logic [3:0]    result_index_q;
  logic          last_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;
  logic          overrun_q;

  irq_edge_detector u_irq_edge (
    .clk_i   (s00_axi_aclk),
    .reset_i (s00_axi_areset),
    .level_i (irq),
    .rise_o  (start)
  );

  assign next_index = index_q + 4'd1;

  // Burst sequencer. All outputs are registered here: the op/number pair is
  // loaded on the transition into ISSUE so it is visible for exactly the
  // ISSUE cycle and cleared on the way out. An edge that lands while a
  // burst is running (DONE included) only marks overrun; the running burst
  // is never disturbed and no second burst is queued.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q        <= ST_IDLE;
      index_q        <= 4'd0;
      wait_cnt_q     <= 2'd0;
      op_q           <= REG_OP_NOP;
      number_q       <= 8'd0;
      data_q         <= 32'd0;
      result_index_q <= 4'd0;
      last_q         <= 1'b0;
      valid_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (start && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            index_q  <= 4'd1;
            busy_q   <= 1'b1;
            op_q     <= REG_OP_READ;
            number_q <= 8'd1;
            state_q  <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          op_q       <= REG_OP_NOP;
          number_q   <= 8'd0;
          wait_cnt_q <= WAIT_LOAD;
          state_q    <= HAS_WAIT ? ST_WAIT : ST_CAPTURE;
        end

        ST_WAIT: begin
          if (wait_cnt_q == 2'd0) begin
            state_q <= ST_CAPTURE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end

        ST_CAPTURE: begin
          data_q         <= register_read;
          result_index_q <= index_q;
          last_q         <= (index_q == LAST_INDEX);
          valid_q        <= 1'b1;
          state_q        <= ST_PRESENT;
        end

        // The beat stays frozen until accepted; the next read is only
        // issued after the handshake, so indices can neither repeat nor
        // be skipped even with ready held high.
        ST_PRESENT: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              index_q  <= next_index;
              op_q     <= REG_OP_READ;
              number_q <= {4'd0, next_index};
              state_q  <= ST_ISSUE;
            end
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FREQ_READER_DETECT_EN
  localparam logic [31:0] THRESHOLD = 32'(DETECT_THRESHOLD);

  logic [PIXEL_COUNT-1:0] detect_q;
  logic [PIXEL_COUNT-1:0] hit_mask;

  // The value being captured this cycle is register_read itself, so the
  // comparison uses it directly rather than waiting for result_data.
  assign hit_mask = (register_read >= THRESHOLD) ? pixel_mask(index_q) : '0;

  // Flags are cleared when a burst starts and accumulate one pixel hit per
  // captured beat; by the done pulse every pixel register has been seen.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      detect_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      detect_q <= '0;
    end else if (state_q == ST_CAPTURE) begin
      detect_q <= detect_q | hit_mask;
    end
  end

  assign detect = detect_q;
`else
  assign detect = 3'b000;
`endif

  assign register_operation = op_q;
  assign register_number    = number_q;
  assign result_data        = data_q;
  assign result_index       = result_index_q;
  assign result_last        = last_q;
  assign result_valid       = valid_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign overrun            = overrun_q;

endmodule

// File: tb/tb_frequency_result_reader.sv
// ---------------------------------------------------------------------------
// tb_frequency_result_reader
//
// Purpose:
//   Self-checking bench for frequency_result_reader. One instance runs with
//   READ_LATENCY=1 and is followed cycle by cycle by a burst-level model;
//   a second instance runs with READ_LATENCY=3 for the latency scenario.
//   Each instance has a register-bank model that returns the programmed
//   value only in the cycle READ_LATENCY after the issue and junk otherwise.
// ---------------------------------------------------------------------------
module tb_frequency_result_reader;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        isLast;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  logic rstSampled = 1'b1;

  int testsRun = 0;
  int testsFailed = 0;

  int regVal [1:7];

  // Main instance signals (READ_LATENCY = 1)
  logic        irq;
  logic [1:0]  regOp;
  logic [7:0]  regNum;
  logic [31:0] regRead = 32'd0;
  logic [31:0] resData;
  logic [3:0]  resIndex;
  logic        resLast;
  logic        resValid;
  logic        resReady;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [2:0]  detect;

  // Second instance signals (READ_LATENCY = 3)
  logic        irq3;
  logic [1:0]  regOp3;
  logic [7:0]  regNum3;
  logic [31:0] regRead3 = 32'd0;
  logic [31:0] resData3;
  logic [3:0]  resIndex3;
  logic        resLast3;
  logic        resValid3;
  logic        resReady3;
  logic        busy3;
  logic        done3;
  logic        overrun3;
  logic [2:0]  detect3;

  frequency_result_reader #(
    .NUM_REGISTERS    (7),
    .READ_LATENCY     (1),
    .DETECT_THRESHOLD (100)
  ) dut (
    .s00_axi_aclk       (clk),
    .s00_axi_areset     (reset),
    .irq                (irq),
    .register_operation (regOp),
    .register_number    (regNum),
    .register_read      (regRead),
    .result_data        (resData),
    .result_index       (resIndex),
    .result_last        (resLast),
    .result_valid       (resValid),
    .result_ready       (resReady),
    .busy               (busy),
    .done               (done),
    .overrun            (overrun),
    .detect             (detect)
  );

  frequency_result_reader #(
    .NUM_REGISTERS    (7),
    .READ_LATENCY     (3),
    .DETECT_THRESHOLD (100)
  ) dut3 (
    .s00_axi_aclk       (clk),
    .s00_axi_areset     (reset),
    .irq                (irq3),
    .register_operation (regOp3),
    .register_number    (regNum3),
    .register_read      (regRead3),
    .result_data        (resData3),
    .result_index       (resIndex3),
    .result_last        (resLast3),
    .result_valid       (resValid3),
    .result_ready       (resReady3),
    .busy               (busy3),
    .done               (done3),
    .overrun            (overrun3),
    .detect             (detect3)
  );

  // Clock, cycle counter and the reset value seen by the last active edge.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rstSampled <= reset;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [31:0] slaveData(input logic [7:0] n);
    if (n >= 8'd1 && n <= 8'd7) return 32'(regVal[n]);
    return 32'hDEAD0000 | {24'd0, n};
  endfunction

  // Register banks: a read issued in cycle c is answered only in cycle c+L.
  logic        ringValid  [8] = '{default: 1'b0};
  logic [31:0] ringData   [8];
  logic        ringValid3 [8] = '{default: 1'b0};
  logic [31:0] ringData3  [8];

  always @(posedge clk) begin
    #1;
    ringValid[cyc & 7] = (regOp == 2'd1);
    ringData[cyc & 7]  = slaveData(regNum);
    regRead = ringValid[(cyc - 1) & 7] ? ringData[(cyc - 1) & 7] : 32'hBAD00000 + 32'(cyc & 32'hFFFF);
    ringValid3[cyc & 7] = (regOp3 == 2'd1);
    ringData3[cyc & 7]  = slaveData(regNum3);
    regRead3 = ringValid3[(cyc - 3) & 7] ? ringData3[(cyc - 3) & 7] : 32'hBAD30000 + 32'(cyc & 32'hFFFF);
  end

  // Pixel p is flagged when either of its two registers reaches 100.
  function automatic logic [2:0] modelDetect();
    logic [2:0] d;
    d = 3'b000;
`ifdef FREQ_READER_DETECT_EN
    for (int p = 0; p < 3; p++) begin
      if (regVal[2*p + 1] >= 100 || regVal[2*p + 2] >= 100) d[p] = 1'b1;
    end
`endif
    return d;
  endfunction

  // Burst-level model of the main instance.
  logic  mBusy = 1'b0;
  logic  mOverrun = 1'b0;
  logic  mIssued = 1'b0;
  logic  prevIrq = 1'b0;
  logic  holdPending = 1'b0;
  int    mExpIdx = 0;
  int    mDoneCycle = -1;
  int    doneCount = 0;
  logic [2:0] detectAtDone = 3'b000;
  beat_t beatLog [$];

  always @(negedge clk) begin
    logic  rising;
    logic  wasBusy;
    beat_t b;
    if (rstSampled) begin
      checkOutput("rst_op", {30'd0, regOp}, 32'd0);
      checkOutput("rst_number", {24'd0, regNum}, 32'd0);
      checkOutput("rst_data", resData, 32'd0);
      checkOutput("rst_index", {28'd0, resIndex}, 32'd0);
      checkOutput("rst_last", {31'd0, resLast}, 32'd0);
      checkOutput("rst_valid", {31'd0, resValid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
      checkOutput("rst_detect", {29'd0, detect}, 32'd0);
      mBusy = 1'b0; mOverrun = 1'b0; mIssued = 1'b0; prevIrq = 1'b0;
      holdPending = 1'b0; mExpIdx = 0; mDoneCycle = -1;
    end else begin
      rising  = irq && !prevIrq;
      prevIrq = irq;
      wasBusy = mBusy;
      checkOutput("busy", {31'd0, busy}, {31'd0, mBusy});
      checkOutput("overrun", {31'd0, overrun}, {31'd0, mOverrun});
      checkOutput("done", {31'd0, done}, {31'd0, (cyc == mDoneCycle)});
      if (regOp != 2'd0) begin
        checkOutput("op_code", {30'd0, regOp}, 32'd1);
        checkOutput("issue_number", {24'd0, regNum}, 32'(mExpIdx));
        checkOutput("issue_once", {31'd0, mIssued}, 32'd0);
        mIssued = 1'b1;
      end else begin
        checkOutput("idle_number", {24'd0, regNum}, 32'd0);
      end
      if (holdPending) checkOutput("valid_held", {31'd0, resValid}, 32'd1);
      if (resValid) begin
        checkOutput("beat_index", {28'd0, resIndex}, 32'(mExpIdx));
        checkOutput("beat_data", resData, (mExpIdx >= 1 && mExpIdx <= 7) ? 32'(regVal[mExpIdx]) : 32'hFFFFFFFF);
        checkOutput("beat_last", {31'd0, resLast}, {31'd0, (mExpIdx == 7)});
        checkOutput("beat_after_issue", {31'd0, mIssued}, 32'd1);
        if (resReady) begin
          b.data = resData; b.idx = resIndex; b.isLast = resLast;
          beatLog.push_back(b);
          if (mExpIdx == 7) begin
            mDoneCycle = cyc + 1;
          end else begin
            mExpIdx++;
            mIssued = 1'b0;
          end
        end
      end
      holdPending = resValid && !resReady;
      if (done) begin
        doneCount++;
        detectAtDone = detect;
      end
      if (cyc == mDoneCycle) begin
        checkOutput("detect_at_done", {29'd0, detect}, {29'd0, modelDetect()});
        mBusy = 1'b0;
        mExpIdx = 0;
      end
      if (rising && wasBusy) mOverrun = 1'b1;
      if (rising && !wasBusy) begin
        mBusy = 1'b1; mExpIdx = 1; mIssued = 1'b0; mDoneCycle = -1;
      end
    end
  end

  // Observation of the READ_LATENCY=3 instance.
  int    issue3Cycle = -1;
  int    firstValid3 = -1;
  int    numHigh3 = 0;
  beat_t beatLog3 [$];

  always @(negedge clk) begin
    beat_t b;
    if (!rstSampled) begin
      if (regOp3 == 2'd1 && regNum3 == 8'd1 && issue3Cycle < 0) issue3Cycle = cyc;
      if (regNum3 != 8'd0 && firstValid3 < 0) numHigh3++;
      if (resValid3 && firstValid3 < 0) firstValid3 = cyc;
      if (resValid3 && resReady3) begin
        b.data = resData3; b.idx = resIndex3; b.isLast = resLast3;
        beatLog3.push_back(b);
      end
    end
  end

  // Bounded wait for a condition; an expired budget is a failed check.
  task automatic applyStimulus(input string name, input int sel);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = done;
        1: hit = done3;
        2: hit = (regOp == 2'd1 && regNum == 8'd4);
        3: hit = (regOp == 2'd1 && regNum == 8'd3);
        4: hit = resValid;
        5: hit = (beatLog.size() >= 2);
        default: hit = 1'b1;
      endcase
    end
    if (!hit) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic raiseIrq();
    irq = 1'b0;
    repeat (2) @(posedge clk);
    #1 irq = 1'b1;
  endtask

  initial begin
    int lastCount;
    logic [2:0] expDetect;
    reset = 1'b1; irq = 1'b0; resReady = 1'b1; irq3 = 1'b0; resReady3 = 1'b1;
    for (int n = 1; n <= 7; n++) regVal[n] = 100 * n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Full burst with ready held high.
    doneCount = 0;
    beatLog.delete();
    raiseIrq();
    applyStimulus("t1_done", 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t1_beats", 32'(beatLog.size()), 32'd7);
    checkOutput("t1_first_idx", {28'd0, beatLog[0].idx}, 32'd1);
    checkOutput("t1_first_data", beatLog[0].data, 32'd100);
    checkOutput("t1_beat4_data", beatLog[3].data, 32'd400);
    checkOutput("t1_last_idx", {28'd0, beatLog[6].idx}, 32'd7);
    checkOutput("t1_last_data", beatLog[6].data, 32'd700);
    lastCount = 0;
    foreach (beatLog[i]) if (beatLog[i].isLast) lastCount++;
    checkOutput("t1_last_count", 32'(lastCount), 32'd1);
    checkOutput("t1_done_count", 32'(doneCount), 32'd1);
    checkOutput("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Backpressure on beat 3.
    beatLog.delete();
    raiseIrq();
    applyStimulus("t2_issue3", 3);
    resReady = 1'b0;
    applyStimulus("t2_valid3", 4);
    repeat (5) begin
      @(negedge clk);
      checkOutput("t2_hold_valid", {31'd0, resValid}, 32'd1);
      checkOutput("t2_hold_idx", {28'd0, resIndex}, 32'd3);
      checkOutput("t2_hold_data", resData, 32'd300);
      checkOutput("t2_no_reissue", {30'd0, regOp}, 32'd0);
    end
    @(posedge clk);
    #1 resReady = 1'b1;
    applyStimulus("t2_done", 0);
    checkOutput("t2_beats", 32'(beatLog.size()), 32'd7);
    checkOutput("t2_beat3_data", beatLog[2].data, 32'd300);
    checkOutput("t2_beat4_idx", {28'd0, beatLog[3].idx}, 32'd4);

    // Second rising edge during beat 4.
    beatLog.delete();
    raiseIrq();
    applyStimulus("t3_issue4", 2);
    irq = 1'b0;
    @(posedge clk);
    #1 irq = 1'b1;
    applyStimulus("t3_done", 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t3_beats", 32'(beatLog.size()), 32'd7);
    checkOutput("t3_overrun", {31'd0, overrun}, 32'd1);
    checkOutput("t3_no_second_burst", {31'd0, busy}, 32'd0);

    // Reset after beat 2, then restart from index 1.
    irq = 1'b0;
    repeat (2) @(posedge clk);
    beatLog.delete();
    #1 irq = 1'b1;
    applyStimulus("t4_two_beats", 5);
    reset = 1'b1;
    irq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t4_op_after_reset", {30'd0, regOp}, 32'd0);
    checkOutput("t4_valid_after_reset", {31'd0, resValid}, 32'd0);
    checkOutput("t4_overrun_cleared", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("t4_no_more_beats", 32'(beatLog.size()), 32'd2);
    beatLog.delete();
    raiseIrq();
    applyStimulus("t4_done", 0);
    checkOutput("t4_restart_idx", {28'd0, beatLog[0].idx}, 32'd1);
    checkOutput("t4_restart_data", beatLog[0].data, 32'd100);
    irq = 1'b0;

    // READ_LATENCY = 3 instance.
    repeat (2) @(posedge clk);
    #1 irq3 = 1'b1;
    applyStimulus("t5_done", 1);
    checkOutput("t5_issue_seen", {31'd0, (issue3Cycle >= 0)}, 32'd1);
    checkOutput("t5_capture_delay", 32'(firstValid3 - issue3Cycle), 32'd4);
    checkOutput("t5_number_width", 32'(numHigh3), 32'd1);
    checkOutput("t5_beats", 32'(beatLog3.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      checkOutput("t5_beat_idx", {28'd0, beatLog3[i].idx}, 32'(i + 1));
      checkOutput("t5_beat_data", beatLog3[i].data, 32'(100 * (i + 1)));
    end
    irq3 = 1'b0;

    // Detection pattern.
    regVal[1] = 50; regVal[2] = 150; regVal[3] = 0; regVal[4] = 0;
    regVal[5] = 99; regVal[6] = 100; regVal[7] = 7;
    beatLog.delete();
    raiseIrq();
    applyStimulus("t6_done", 0);
`ifdef FREQ_READER_DETECT_EN
    expDetect = 3'b101;
`else
    expDetect = 3'b000;
`endif
    checkOutput("t6_detect", {29'd0, detectAtDone}, {29'd0, expDetect});
    checkOutput("t6_beat2_data", beatLog[1].data, 32'd150);
    checkOutput("t6_beat7_data", beatLog[6].data, 32'd7);
    irq = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
